hcsr04_array: RTL
=================

# hcsr04_array

Multi-channel HC-SR04 ranging scheduler: fires up to CHANNELS ultrasonic sensors one at a time in ascending index order and reports one echo length per channel. Each sweep runs in one-shot or continuous mode. A timeout flags any channel with a missing or stuck echo. Every channel gets an inter-ping recovery gap to suppress crosstalk. Prescaler, trigger generation and echo capture are all internal, in a single clock domain. The block sits between the sensor pins and the ranging/map logic.

## Interface
Parameters:
- CHANNELS, 4, number of sensors (1..16)
- CH_LEN, 2, width of the channel index; must satisfy 2^CH_LEN >= CHANNELS
- CAP_LEN, 16, width of the echo length in µs
- FD_F, 50, clk50M cycles per µs tick
- TRIG_US, 10, trigger pulse width in ticks
- ECHO_TIMEOUT_US, 30000, max ticks spent waiting for the echo rise, and separately max ticks of echo high
- GAP_US, 60000, recovery ticks after each ping
- TCNT_LEN, 17, width of the tick timer; must hold max(ECHO_TIMEOUT_US, GAP_US)

Ports:
- clk50M  in  1  50 MHz clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request for one sweep
- continuous  in  1  when high, sweeps repeat back-to-back
- ch_mask  in  CHANNELS  enabled channels
- sig_len  in  CHANNELS  echo inputs, asynchronous
- sig_trig  out  CHANNELS  trigger outputs, registered
- len  out  CAP_LEN  last result
- len_ch  out  CH_LEN  channel index of the last result
- timeout  out  1  last result timed out
- valid  out  1  one-cycle pulse when len, len_ch and timeout update
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at the end of a sweep

## Operation
- Each sig_len bit passes through a 2-FF synchronizer. The rising-edge detect uses the synchronized value and its 1-cycle delay.
- Tick prescaler counts 0..FD_F-1 and is cleared on every state transition. All durations are therefore exact multiples of FD_F cycles.
- IDLE:
  - If (start | continuous) and ch_mask != 0: latch the mask, set cur = lowest set bit, go to TRIG.
  - If ch_mask == 0: stay in IDLE; no done.
  - start while busy is ignored.
- TRIG: sig_trig[cur] = 1 for TRIG_US ticks, then go to WAIT_RISE. All other sig_trig bits stay 0.
- WAIT_RISE:
  - On a synchronized 0→1 edge of sig_len[cur], go to MEASURE.
  - If ECHO_TIMEOUT_US ticks elapse with no edge, go to REPORT with timeout=1. An echo already high without an edge also ends this way.
- MEASURE:
  - Count ticks while echo is high; the count saturates at 2^CAP_LEN-1.
  - On synchronized low, go to REPORT with len = count.
  - If the count reaches ECHO_TIMEOUT_US, go to REPORT with timeout=1.
- REPORT (1 cycle):
  - Register len, len_ch=cur and timeout, and pulse valid. On timeout, len = all ones.
  - Then go to GAP.
- GAP: wait GAP_US ticks. Then:
  - If the latched mask has a set bit above cur, cur = next set bit and go to TRIG.
  - Otherwise pulse done. If continuous, restart at the lowest set bit of a freshly latched ch_mask and go to TRIG; otherwise go to IDLE.
- Mask changes and continuous deassertion take effect only at sweep boundaries; the current sweep always completes.
- Echoes on non-selected channels are ignored.

## Timing
- Reset: every output is 0 and state is IDLE one edge after rst is sampled high. This includes mid-TRIG: sig_trig drops on that edge and no valid or done follows.
- The start sampled at edge N gives sig_trig[cur] high from edge N+1 for exactly TRIG_US*FD_F cycles.
- An echo high for H cycles measures len = floor(H/FD_F). Synchronizer delay cancels between the two edges.
- valid rises on the 3rd edge after the first edge that samples sig_len low: 2 synchronizer stages plus the state register.
- done asserts in the cycle GAP expires for the last enabled channel. When continuous, the next trigger starts the following cycle.
- Outputs len, len_ch and timeout hold between valid pulses.

## Test plan
Bench parameters: FD_F=5, TRIG_US=2, ECHO_TIMEOUT_US=20, GAP_US=4, CHANNELS=4.
- Reset: hold rst 3 cycles with random inputs -> all outputs 0 and busy=0.
- Single channel: mask=0001, pulse start, drive sig_len[0] high for 37 cycles starting 5 cycles after the trigger falls -> sig_trig[0] high 10 cycles; one valid with len=7, len_ch=0, timeout=0; done 20 cycles after REPORT; busy then 0.
- Sweep with mask=1010 and echoes of 25 and 50 cycles -> triggers only on channels 1 then 3; valids report len=5/ch=1 then len=10/ch=3; exactly one done.
- No echo on channel 2 (mask=0100) -> valid after 100 cycles in WAIT_RISE with timeout=1 and len=0xFFFF.
- Echo stuck high from before the trigger -> timeout=1. Echo rising but high for 200 cycles -> timeout=1 when MEASURE reaches 20 ticks.
- continuous=1, mask=0011 -> sweeps repeat with a done between them. Deassert continuous mid-sweep -> that sweep ends with done, then IDLE. rst asserted mid-MEASURE -> outputs 0 next edge and no valid.

Source files
------------

// File: rtl/hcsr04_array.sv
// hcsr04_array: multi-channel HC-SR04 ranging scheduler.
// Fires the enabled sensors one at a time in ascending index order. Each
// channel gets a trigger pulse, then its echo is measured in microsecond
// ticks, reported once, and followed by a recovery gap before the next ping.
module hcsr04_array #(
  parameter int CHANNELS        = 4,
  parameter int CH_LEN          = 2,
  parameter int CAP_LEN         = 16,
  parameter int FD_F            = 50,
  parameter int TRIG_US         = 10,
  parameter int ECHO_TIMEOUT_US = 30000,
  parameter int GAP_US          = 60000,
  parameter int TCNT_LEN        = 17
) (
  input  logic                clk50M,
  input  logic                rst,
  input  logic                start,
  input  logic                continuous,
  input  logic [CHANNELS-1:0] ch_mask,
  input  logic [CHANNELS-1:0] sig_len,
  output logic [CHANNELS-1:0] sig_trig,
  output logic [CAP_LEN-1:0]  len,
  output logic [CH_LEN-1:0]   len_ch,
  output logic                timeout,
  output logic                valid,
  output logic                busy,
  output logic                done
);

  localparam int unsigned NCH = CHANNELS;
  localparam int PS_LEN = (FD_F > 1) ? $clog2(FD_F) : 1;
  localparam logic [PS_LEN-1:0]   PS_LAST   = PS_LEN'(FD_F - 1);
  localparam logic [TCNT_LEN-1:0] TRIG_LAST = TCNT_LEN'(TRIG_US - 1);
  localparam logic [TCNT_LEN-1:0] ECHO_LAST = TCNT_LEN'(ECHO_TIMEOUT_US - 1);
  localparam logic [TCNT_LEN-1:0] GAP_LAST  = TCNT_LEN'(GAP_US - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_REPORT,
    S_GAP
  } state_t;

  state_t state, state_n;

  logic [CH_LEN-1:0]   cur, cur_n;
  logic [CH_LEN-1:0]   first_ch, next_ch;
  logic                first_ok, next_ok;
  logic [CHANNELS-1:0] mask_q, mask_n;

  logic [CHANNELS-1:0] sync_a, sync_b, sync_d;
  logic                echo_lvl, echo_prev, echo_rise;

  logic [PS_LEN-1:0]   pcnt;
  logic                tick;
  logic [TCNT_LEN-1:0] tcnt;
  logic [CAP_LEN-1:0]  mcnt, mcnt_inc, rep_len;
  logic                rep, rep_to;

  // Two-stage synchronizer per echo input plus one delayed copy for edge detection
  always_ff @(posedge clk50M) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      sync_d <= '0;
    end else begin
      sync_a <= sig_len;
      sync_b <= sync_a;
      sync_d <= sync_b;
    end
  end

  // Select the synchronized echo of the channel currently being pinged
  always_comb begin
    echo_lvl  = 1'b0;
    echo_prev = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cur == CH_LEN'(i)) begin
        echo_lvl  = sync_b[i];
        echo_prev = sync_d[i];
      end
    end
  end

  assign echo_rise = echo_lvl & ~echo_prev;
  assign tick      = (pcnt == PS_LAST);
  assign mcnt_inc  = (mcnt == '1) ? mcnt : mcnt + 1'b1;
  assign busy      = (state != S_IDLE);

  // Lowest enabled channel of the live mask, and next latched channel above cur
  always_comb begin
    first_ch = '0;
    first_ok = 1'b0;
    next_ch  = '0;
    next_ok  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_mask[i] && !first_ok) begin
        first_ch = CH_LEN'(i);
        first_ok = 1'b1;
      end
      if (mask_q[i] && !next_ok && (CH_LEN'(i) > cur)) begin
        next_ch = CH_LEN'(i);
        next_ok = 1'b1;
      end
    end
  end

  // Next-state logic, result capture requests and the sweep-done pulse
  always_comb begin
    state_n = state;
    cur_n   = cur;
    mask_n  = mask_q;
    rep     = 1'b0;
    rep_to  = 1'b0;
    rep_len = '0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if ((start || continuous) && (ch_mask != '0)) begin
          mask_n  = ch_mask;
          cur_n   = first_ch;
          state_n = S_TRIG;
        end
      end
      S_TRIG: begin
        if (tick && (tcnt == TRIG_LAST)) state_n = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (echo_rise) begin
          state_n = S_MEASURE;
        end else if (tick && (tcnt == ECHO_LAST)) begin
          state_n = S_REPORT;
          rep     = 1'b1;
          rep_to  = 1'b1;
          rep_len = '1;
        end
      end
      S_MEASURE: begin
        // The rise cycle was spent in WAIT_RISE, so the falling cycle's tick
        // is still credited; the synchronizer latency cancels out.
        if (!echo_lvl) begin
          state_n = S_REPORT;
          rep     = 1'b1;
          rep_len = tick ? mcnt_inc : mcnt;
        end else if (tick && (tcnt == ECHO_LAST)) begin
          state_n = S_REPORT;
          rep     = 1'b1;
          rep_to  = 1'b1;
          rep_len = '1;
        end
      end
      S_REPORT: begin
        state_n = S_GAP;
      end
      S_GAP: begin
        if (tick && (tcnt == GAP_LAST)) begin
          if (next_ok) begin
            cur_n   = next_ch;
            state_n = S_TRIG;
          end else begin
            done = 1'b1;
            if (continuous && (ch_mask != '0)) begin
              mask_n  = ch_mask;
              cur_n   = first_ch;
              state_n = S_TRIG;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register, latched sweep context and the tick prescaler/timers
  always_ff @(posedge clk50M) begin
    if (rst) begin
      state  <= S_IDLE;
      cur    <= '0;
      mask_q <= '0;
      pcnt   <= '0;
      tcnt   <= '0;
      mcnt   <= '0;
    end else begin
      state  <= state_n;
      cur    <= cur_n;
      mask_q <= mask_n;
      if (state_n != state) begin
        pcnt <= '0;
        tcnt <= '0;
      end else if (tick) begin
        pcnt <= '0;
        tcnt <= tcnt + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
      if (state != S_MEASURE) begin
        mcnt <= '0;
      end else if (tick) begin
        mcnt <= mcnt_inc;
      end
    end
  end

  // Trigger outputs follow the TRIG state one cycle later, only on cur
  always_ff @(posedge clk50M) begin
    if (rst) begin
      sig_trig <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        sig_trig[i] <= (state == S_TRIG) && (cur == CH_LEN'(i));
      end
    end
  end

  // Result registers: updated together with a one-cycle valid pulse
  always_ff @(posedge clk50M) begin
    if (rst) begin
      len     <= '0;
      len_ch  <= '0;
      timeout <= 1'b0;
      valid   <= 1'b0;
    end else begin
      valid <= rep;
      if (rep) begin
        len     <= rep_len;
        len_ch  <= cur;
        timeout <= rep_to;
      end
    end
  end

endmodule
